// File: rtl/saph_span_coeff_gen.sv
// -----------------------------------------------------------------------------
// saph_span_coeff_gen
//
// Walks a blend coefficient across a span of pixels. A span command gives a
// pixel count, an 8.8 start coefficient and an 8.8 per-pixel step (added or
// subtracted). One beat per pixel is emitted with a valid/ready handshake.
// The coefficient accumulator saturates instead of wrapping.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  span command offered
//   cmd_ready  command accepted when high together with cmd_valid
//   cmd_len    pixel count (0 = empty span, consumed without beats)
//   cmd_start  initial coefficient, unsigned 8.8
//   cmd_step   per-pixel increment magnitude, unsigned 8.8
//   cmd_dec    1 = subtract step per pixel, 0 = add
//   px_valid   pixel beat present
//   px_ready   downstream accepts beat
//   px_coeff   integer part of the accumulator for this pixel
//   px_index   zero-based pixel index within the span
//   px_last    beat is the final pixel of the span
//   busy       high while a span is in progress
// -----------------------------------------------------------------------------
module saph_span_coeff_gen #(
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [15:0]      cmd_start,
    input  logic [15:0]      cmd_step,
    input  logic             cmd_dec,
    output logic             px_valid,
    input  logic             px_ready,
    output logic [7:0]       px_coeff,
    output logic [LEN_W-1:0] px_index,
    output logic             px_last,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state;
    logic [15:0]      acc;
    logic [15:0]      step_q;
    logic             dec_q;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] rem;
    logic             valid_q;
    logic             busy_q;

    logic             beat_accept;
    logic             last_accept;
    logic             load;
    logic [16:0]      sum17;
    logic [16:0]      diff17;
    logic [15:0]      acc_next;

    assign beat_accept = valid_q & px_ready;
    assign last_accept = beat_accept & (rem == ONE);

    // A new command may only enter while idle or in the very cycle the last
    // beat leaves, which is what lets back-to-back spans run without a bubble.
    assign cmd_ready = (state == IDLE) | last_accept;
    assign load      = cmd_valid & cmd_ready & (cmd_len != '0);

    // Saturating accumulator update; the 17th bit is the carry/borrow.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        acc_next = acc;
        sum17    = {1'b0, acc} + {1'b0, step_q};
        diff17   = {1'b0, acc} - {1'b0, step_q};
        if (dec_q) begin
            acc_next = diff17[16] ? 16'h0000 : diff17[15:0];
        end else begin
            acc_next = sum17[16] ? 16'hFFFF : sum17[15:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            step_q  <= '0;
            dec_q   <= 1'b0;
            idx     <= '0;
            rem     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (load) begin
            // Covers both a fresh start from IDLE and the seamless hand-over
            // when the previous span's last beat is accepted this cycle.
            state   <= RUN;
            acc     <= cmd_start;
            step_q  <= cmd_step;
            dec_q   <= cmd_dec;
            idx     <= '0;
            rem     <= cmd_len;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
        end else if (state == RUN && beat_accept) begin
            if (rem == ONE) begin
                // Clearing rem keeps px_last low while idle.
                state   <= IDLE;
                rem     <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                acc <= acc_next;
                idx <= idx + ONE;
                rem <= rem - ONE;
            end
        end
    end

    assign px_valid = valid_q;
    assign px_coeff = acc[15:8];
    assign px_index = idx;
    assign px_last  = (rem == ONE);
    assign busy     = busy_q;

endmodule

// File: tb/tb_saph_span_coeff_gen.sv
// -----------------------------------------------------------------------------
// tb_saph_span_coeff_gen
//
// Directed bench for saph_span_coeff_gen. Expected beats are pushed to a
// scoreboard queue when a command is driven and popped when the DUT hands a
// beat over (px_valid & px_ready sampled on the falling edge).
// -----------------------------------------------------------------------------
module tb_saph_span_coeff_gen;

    localparam int LEN_W = 12;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [15:0]      cmd_start;
    logic [15:0]      cmd_step;
    logic             cmd_dec;
    logic             px_valid;
    logic             px_ready;
    logic [7:0]       px_coeff;
    logic [LEN_W-1:0] px_index;
    logic             px_last;
    logic             busy;

    saph_span_coeff_gen #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_start (cmd_start),
        .cmd_step  (cmd_step),
        .cmd_dec   (cmd_dec),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_coeff  (px_coeff),
        .px_index  (px_index),
        .px_last   (px_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       coeff;
        logic [LEN_W-1:0] index;
        logic             last;
    } beat_t;

    beat_t sb[$];

    int   checks = 0;
    int   errors = 0;
    logic cmd_acc;
    logic s_cmd_ready;
    logic s_px_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] c, input int i, input logic l);
        beat_t b;
        b.coeff = c;
        b.index = LEN_W'(i);
        b.last  = l;
        sb.push_back(b);
    endtask

    // One clock: sample on the falling edge (score any handshake that the
    // coming rising edge will complete), then return 1 time unit after it.
    task automatic cycle();
        beat_t b;
        @(negedge clk);
        s_cmd_ready = cmd_ready;
        s_px_valid  = px_valid;
        cmd_acc     = cmd_valid & cmd_ready;
        if (px_valid && px_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                b = sb.pop_front();
                chk("px_coeff", 32'(px_coeff), 32'(b.coeff));
                chk("px_index", 32'(px_index), 32'(b.index));
                chk("px_last",  32'(px_last),  32'(b.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int len, input logic [15:0] start,
                        input logic [15:0] step, input logic dec);
        int n;
        cmd_len   = LEN_W'(len);
        cmd_start = start;
        cmd_step  = step;
        cmd_dec   = dec;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!cmd_acc && n < 50);
        chk("cmd_accept", 32'(cmd_acc), 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        // Last beat accepted: idle on the following cycle.
        chk("idle_valid", 32'(px_valid), 32'd0);
        chk("idle_busy",  32'(busy),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_start = '0;
        cmd_step  = '0;
        cmd_dec   = 1'b0;
        px_ready  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_px_valid",  32'(px_valid),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_px_coeff",  32'(px_coeff),  32'd0);
        chk("rst_px_index",  32'(px_index),  32'd0);
        chk("rst_px_last",   32'(px_last),   32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp: four beats stepping by 0x40, first beat one cycle after accept
        push(8'h00, 0, 1'b0);
        push(8'h40, 1, 1'b0);
        push(8'h80, 2, 1'b0);
        push(8'hC0, 3, 1'b1);
        send(4, 16'h0000, 16'h4000, 1'b0);
        chk("lat_px_valid", 32'(px_valid), 32'd1);
        chk("lat_busy",     32'(busy),     32'd1);
        drain(20);

        // Add saturation at 0xFFFF
        push(8'hF0, 0, 1'b0);
        push(8'hFF, 1, 1'b0);
        push(8'hFF, 2, 1'b1);
        send(3, 16'hF000, 16'h1000, 1'b0);
        drain(20);

        // Subtract saturation at 0x0000
        push(8'h10, 0, 1'b0);
        push(8'h00, 1, 1'b0);
        push(8'h00, 2, 1'b1);
        send(3, 16'h1000, 16'h1000, 1'b1);
        drain(20);

        // Stall on beat 1 for five cycles
        px_ready = 1'b0;
        push(8'h20, 0, 1'b0);
        push(8'h28, 1, 1'b0);
        push(8'h30, 2, 1'b1);
        send(3, 16'h2000, 16'h0800, 1'b0);
        px_ready = 1'b1;
        cycle();
        px_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_valid",     32'(px_valid),    32'd1);
            chk("stall_coeff",     32'(px_coeff),    32'h28);
            chk("stall_index",     32'(px_index),    32'd1);
            chk("stall_last",      32'(px_last),     32'd0);
            chk("stall_cmd_ready", 32'(s_cmd_ready), 32'd0);
        end
        px_ready = 1'b1;
        drain(20);

        // Back-to-back spans with cmd_valid held: no bubble between them
        push(8'h01, 0, 1'b0);
        push(8'h02, 1, 1'b1);
        push(8'h55, 0, 1'b1);
        cmd_len   = LEN_W'(2);
        cmd_start = 16'h0100;
        cmd_step  = 16'h0100;
        cmd_dec   = 1'b0;
        cmd_valid = 1'b1;
        cycle();
        chk("b2b_accept1", 32'(cmd_acc), 32'd1);
        cmd_len   = LEN_W'(1);
        cmd_start = 16'h5500;
        cmd_step  = 16'h0000;
        cycle();
        chk("b2b_a_valid", 32'(s_px_valid),  32'd1);
        chk("b2b_a_ready", 32'(s_cmd_ready), 32'd0);
        cycle();
        chk("b2b_b_valid", 32'(s_px_valid),  32'd1);
        chk("b2b_b_ready", 32'(s_cmd_ready), 32'd1);
        chk("b2b_accept2", 32'(cmd_acc),     32'd1);
        cmd_valid = 1'b0;
        cycle();
        chk("b2b_c_valid", 32'(s_px_valid),  32'd1);
        chk("b2b_c_ready", 32'(s_cmd_ready), 32'd1);
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
        chk("b2b_idle_valid", 32'(px_valid), 32'd0);

        // Empty span: consumed, no beat, never busy
        send(0, 16'h1234, 16'h0100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("len0_valid", 32'(px_valid), 32'd0);
            chk("len0_busy",  32'(busy),     32'd0);
            cycle();
        end

        // Reset mid-span of len 8
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i), i, i == 7);
        send(8, 16'h1000, 16'h0100, 1'b0);
        cycle();
        cycle();
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(px_valid), 32'd0);
        chk("mid_rst_busy",  32'(busy),     32'd0);
        chk("mid_rst_index", 32'(px_index), 32'd0);
        chk("mid_rst_coeff", 32'(px_coeff), 32'd0);
        chk("mid_rst_consumed", 32'(sb.size()), 32'd5);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        push(8'hAB, 0, 1'b0);
        push(8'hAC, 1, 1'b1);
        send(2, 16'hAB00, 16'h0100, 1'b0);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
